// File: rtl/task_write_raw.sv
// Raw-path SD write test task: resets sdspihost, writes BYTES_TO_WRITE bytes from FIRST_BLOCK, times the run.
// Optional: define TASK_WRITE_RAW_LFSR_EN to source data_in from an 8-bit Galois LFSR instead of the counter pattern.
module task_write_raw #(
    parameter int unsigned BYTES_TO_WRITE = 32 << 9,
    parameter logic [31:0] FIRST_BLOCK    = 32'd43,
    parameter int unsigned RST_CYCLES     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        spi_ctl,
    output logic        rst_eluks,
    output logic        rst_spi,
    output logic        w_block,
    output logic        w_byte,
    output logic [7:0]  data_in,
    output logic [31:0] block_addr,
    input  logic        spi_busy,
    input  logic        spi_err,
    output logic        end_signal,
    output logic        error,
    output logic [63:0] exec_time
);
    if (BYTES_TO_WRITE < 512 || (BYTES_TO_WRITE % 512) != 0) begin : g_bad_size
        $error("task_write_raw: BYTES_TO_WRITE must be a non-zero multiple of 512");
    end

    localparam logic [31:0] NUM_BLOCKS = 32'(BYTES_TO_WRITE / 512);
    localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);

    typedef enum logic [3:0] {
        S_RST_SPI, S_WAIT_INIT, S_START_BLK, S_WAIT_ACC, S_WAIT_RDY,
        S_SEND, S_WAIT_SHIFT, S_WAIT_BLK, S_END, S_ERROR
    } state_t;

    state_t      state, state_nx;
    logic [31:0] rst_cnt, rst_cnt_nx;
    logic        init_seen, init_seen_nx;
    logic [8:0]  byte_cnt, byte_cnt_nx;
    logic [31:0] blk_cnt, blk_cnt_nx;
    logic [7:0]  data_nx, pattern;
    logic [31:0] addr_nx;
    logic        w_block_nx, working;

    assign spi_ctl   = 1'b0;
    assign rst_eluks = 1'b1;

`ifdef TASK_WRITE_RAW_LFSR_EN
    logic [7:0] lfsr;

    // Advances once per byte sent; never reseeded between blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 8'h01;
        end else if (state == S_SEND) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 8'hB8 : 8'h00);
        end
    end

    assign pattern = lfsr;
`else
    assign pattern = byte_cnt[7:0] ^ blk_cnt[7:0];
`endif

    assign working = (state inside {S_START_BLK, S_WAIT_ACC, S_WAIT_RDY,
                                    S_SEND, S_WAIT_SHIFT, S_WAIT_BLK});

    always_comb begin
        state_nx     = state;
        rst_cnt_nx   = rst_cnt;
        init_seen_nx = init_seen;
        byte_cnt_nx  = byte_cnt;
        blk_cnt_nx   = blk_cnt;
        data_nx      = data_in;
        addr_nx      = block_addr;
        w_block_nx   = 1'b0;
        case (state)
            S_RST_SPI: begin
                if (rst_cnt == RST_LAST) state_nx = S_WAIT_INIT;
                else rst_cnt_nx = rst_cnt + 32'd1;
            end
            S_WAIT_INIT: begin
                if (!init_seen) begin
                    if (spi_busy) init_seen_nx = 1'b1;
                end else if (!spi_busy) begin
                    state_nx = S_START_BLK;
                end
            end
            S_START_BLK: state_nx = S_WAIT_ACC;
            S_WAIT_ACC: if (spi_busy) state_nx = S_WAIT_RDY;
            S_WAIT_RDY: begin
                if (!spi_busy) begin
                    data_nx  = pattern;
                    state_nx = S_SEND;
                end
            end
            S_SEND: state_nx = S_WAIT_SHIFT;
            S_WAIT_SHIFT: begin
                if (spi_busy) begin
                    byte_cnt_nx = byte_cnt + 9'd1;
                    state_nx    = (byte_cnt == 9'd511) ? S_WAIT_BLK : S_WAIT_RDY;
                end
            end
            S_WAIT_BLK: begin
                if (!spi_busy) begin
                    blk_cnt_nx = blk_cnt + 32'd1;
                    state_nx   = (blk_cnt_nx == NUM_BLOCKS) ? S_END : S_START_BLK;
                end
            end
            default: state_nx = state;
        endcase

        // A host error wins over whatever the step above decided.
        if (working && spi_err) begin
            state_nx    = S_ERROR;
            byte_cnt_nx = byte_cnt;
            blk_cnt_nx  = blk_cnt;
            data_nx     = data_in;
        end

        if (state_nx == S_START_BLK) addr_nx = FIRST_BLOCK + blk_cnt_nx;

        // w_block drops for the START_BLK cycle between blocks so the host sees a fresh rise.
        case (state_nx)
            S_START_BLK: w_block_nx = (state != S_WAIT_BLK);
            S_WAIT_ACC, S_WAIT_RDY, S_SEND, S_WAIT_SHIFT, S_WAIT_BLK: w_block_nx = 1'b1;
            default: w_block_nx = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RST_SPI;
            rst_cnt    <= '0;
            init_seen  <= 1'b0;
            byte_cnt   <= '0;
            blk_cnt    <= '0;
            rst_spi    <= 1'b1;
            w_block    <= 1'b0;
            w_byte     <= 1'b0;
            data_in    <= '0;
            block_addr <= FIRST_BLOCK;
            end_signal <= 1'b0;
            error      <= 1'b0;
            exec_time  <= '0;
        end else begin
            state      <= state_nx;
            rst_cnt    <= rst_cnt_nx;
            init_seen  <= init_seen_nx;
            byte_cnt   <= byte_cnt_nx;
            blk_cnt    <= blk_cnt_nx;
            rst_spi    <= (state_nx == S_RST_SPI);
            w_block    <= w_block_nx;
            w_byte     <= (state_nx == S_SEND);
            data_in    <= data_nx;
            block_addr <= addr_nx;
            end_signal <= end_signal | (state_nx == S_END);
            error      <= error | (state_nx == S_ERROR);
            if (working) exec_time <= exec_time + 64'd1;
        end
    end
endmodule
